// File: rtl/arb_pkg.sv
// Shared definitions for the grant/data stage: port count, output FSM state
// encoding and a helper turning a grant vector into a port index.
package arb_pkg;

  localparam int unsigned NPORT = 4;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [1:0] onehot_to_idx(input logic [NPORT-1:0] oh);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (oh[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Grant encoder: turns the arbiter grant vector into a port index plus a flag
// saying whether the grant may select a port.
// Build option GRANT_ONEHOT_CHK_EN: when defined only an exactly-one-hot grant
// is legal; otherwise any non-zero grant is legal and resolves to its lowest bit.
module onehot_enc
  import arb_pkg::*;
(
  input  logic [NPORT-1:0] grant,
  output logic [1:0]       idx,
  output logic             legal
);

  // Index decode and legality check are purely combinational.
  always_comb begin
    idx = onehot_to_idx(grant);
`ifdef GRANT_ONEHOT_CHK_EN
    // Non-zero with no second bit set.
    legal = (grant != '0) && ((grant & (grant - NPORT'(1))) == '0);
`else
    legal = (grant != '0);
`endif
  end

endmodule

// File: rtl/grant_data_stage.sv
// Output register stage behind a 4-port round-robin arbiter. Captures the
// granted port's beat into a single-entry slot, acknowledges it with a
// one-cycle in_ack pulse and counts beats taken during the current grant.
// Build option GRANT_ONEHOT_CHK_EN: multi-hot grants are refused and flagged on
// the sticky grant_err output; without it they resolve to the lowest set bit
// and grant_err is tied low.
module grant_data_stage
  import arb_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NPORT-1:0]    grant,
  input  logic [NPORT-1:0]    in_valid,
  input  logic [NPORT*DW-1:0] in_data,
  output logic [NPORT-1:0]    in_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [1:0]          out_src,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                grant_err
);

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NPORT-1:0] grant_q;

  logic [1:0]       grant_idx;
  logic             grant_legal;
  logic [DW-1:0]    sel_data;
  logic             sel_valid;
  logic             slot_free;
  logic             capture;

  onehot_enc u_onehot_enc (
    .grant (grant),
    .idx   (grant_idx),
    .legal (grant_legal)
  );

  // Select the granted port and decide whether its beat is taken this cycle.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (2'(i) == grant_idx) begin
        sel_data = in_data[i*DW +: DW];
      end
    end
    sel_valid = in_valid[grant_idx];
    slot_free = (state_q == StEmpty) || out_ready;
    // Gating with rst_n keeps in_ack quiet while reset is held.
    capture   = rst_n && slot_free && grant_legal && sel_valid;
    in_ack    = capture ? (NPORT'(1) << grant_idx) : '0;
  end

  // Next state of the slot, its payload and the per-tenure beat counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (capture) begin
      state_d = StFull;
      data_d  = sel_data;
      src_d   = grant_idx;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
    // A new grant value starts a new tenure; the capture in that cycle is its first beat.
    if (grant != grant_q) begin
      cnt_d = capture ? CNT_W'(1) : '0;
    end else if (capture && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output FSM with registered payload; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      grant_q <= grant;
    end
  end

`ifdef GRANT_ONEHOT_CHK_EN
  logic err_q, err_d;

  // Any multi-hot grant latches the error until reset.
  always_comb begin
    err_d = err_q | ((grant != '0) && !grant_legal);
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign grant_err = err_q;
`else
  assign grant_err = 1'b0;
`endif

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_grant_data_stage.sv
// Self-checking bench for grant_data_stage: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_grant_data_stage;

  localparam int DW    = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst_n;
  logic [3:0]      grant;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ack;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic [CNT_W-1:0] beat_cnt;
  logic            grant_err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit         m_valid;
  int         m_data;
  int         m_src;
  int         m_cnt;
  bit         m_err;
  logic [3:0] m_prev;

  grant_data_stage #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant     (grant),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .beat_cnt  (beat_cnt),
    .grant_err (grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_idx(input logic [3:0] gr);
    for (int i = 0; i < 4; i++) if (gr[i]) return i;
    return 0;
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_data  = 0;
    m_src   = 0;
    m_cnt   = 0;
    m_err   = 0;
    m_prev  = 4'b0000;
  endfunction

  task automatic set_port(input int p, input logic [DW-1:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  // One clock: entered at posedge+1 with inputs applied, returns at next posedge+1.
  task automatic cycle();
    bit         legal;
    bit         cap;
    int         g;
    logic [3:0] eack;
    #3;
`ifdef GRANT_ONEHOT_CHK_EN
    legal = ($countones(grant) == 1);
`else
    legal = (grant != 4'b0000);
`endif
    g    = low_idx(grant);
    cap  = legal && in_valid[g] && (!m_valid || out_ready);
    eack = cap ? 4'(1 << g) : 4'b0000;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_src", 32'(out_src), 32'(m_src));
    end
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    chk("grant_err", 32'(grant_err), 32'(m_err));
    chk("in_ack", 32'(in_ack), 32'(eack));
    @(posedge clk);
    if (cap) begin
      m_valid = 1;
      m_data  = int'(in_data[g*DW +: DW]);
      m_src   = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (grant != m_prev) m_cnt = cap ? 1 : 0;
    else if (cap && m_cnt != CMAX) m_cnt++;
    m_prev = grant;
`ifdef GRANT_ONEHOT_CHK_EN
    if ($countones(grant) > 1) m_err = 1;
`endif
    #1;
  endtask

  // Asynchronous reset pulse starting at posedge+1; releases at the following posedge+1.
  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_grant_err", 32'(grant_err), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    grant     = 4'b0000;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #2;
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_in_ack", 32'(in_ack), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic capture right after reset release.
    grant = 4'b0001; in_valid = 4'b0001; set_port(0, 8'hA5); out_ready = 1'b1;
    cycle();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'hA5);
    chk("basic_src", 32'(out_src), 32'd0);
    in_valid = 4'b0000;
    cycle();

    // Stall: hold 0x3C while port 1 waits, then swap in one cycle.
    in_valid = 4'b0001; set_port(0, 8'h3C);
    cycle();
    out_ready = 1'b0; grant = 4'b0010; in_valid = 4'b0010; set_port(1, 8'h77);
    repeat (3) cycle();
    chk("stall_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    cycle();
    chk("swap_data", 32'(out_data), 32'h77);
    chk("swap_src", 32'(out_src), 32'd1);
    in_valid = 4'b0000;
    cycle();

    // Streaming from port 2 for 20 cycles.
    grant = 4'b0100; in_valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      set_port(2, 8'($urandom));
      cycle();
    end
    chk("stream_cnt_sat", 32'(beat_cnt), 32'(CMAX));
    chk("stream_src", 32'(out_src), 32'd2);
    in_valid = 4'b0000;
    cycle();

    // Grant change while a port-3 beat is held.
    grant = 4'b1000; in_valid = 4'b1000; set_port(3, 8'hD2);
    cycle();
    out_ready = 1'b0; in_valid = 4'b0000; grant = 4'b0001;
    cycle();
    chk("gchg_src", 32'(out_src), 32'd3);
    chk("gchg_cnt", 32'(beat_cnt), 32'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    chk("gchg_drained", 32'(out_valid), 32'd0);

    // Multi-hot grant.
    grant = 4'b0110; in_valid = 4'b0110; set_port(1, 8'h11); set_port(2, 8'h22);
    cycle();
`ifdef GRANT_ONEHOT_CHK_EN
    chk("multi_nocap", 32'(out_valid), 32'd0);
    chk("multi_err", 32'(grant_err), 32'd1);
`else
    chk("multi_src", 32'(out_src), 32'd1);
    chk("multi_err", 32'(grant_err), 32'd0);
`endif
    grant = 4'b0001; in_valid = 4'b0000;
    repeat (2) cycle();

    // Reset while a beat is held and stalled.
    grant = 4'b0010; in_valid = 4'b0010; set_port(1, 8'h5A); out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; in_valid = 4'b0000;
    cycle();
    pulse_reset();
    // First edge after release must capture.
    grant = 4'b0100; in_valid = 4'b0100; set_port(2, 8'hC7); out_ready = 1'b1;
    cycle();
    chk("post_rst_cap", 32'(out_data), 32'hC7);

    // Random traffic, mostly one-hot grants held for a few cycles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0:       grant = 4'b0000;
          1:       grant = 4'($urandom);
          default: grant = 4'(1 << $urandom_range(0, 3));
        endcase
      end
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 250) pulse_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
